rgmii_rx_decode: RTL and testbench



---
 rtl/rgmii_rx_decode.sv | 189 ++++++++++++++++++
 tb/tb_rgmii_rx_decode.sv | 307 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rgmii_rx_decode.sv
// RGMII receive decode: rebuilds the GMII byte stream, tracks in-band link status and
// delivers the de-preambled payload as a framed stream with good/bad frame counters.
module rgmii_rx_decode #(
    parameter int unsigned MIN_PREAMBLE  = 1,
    parameter int unsigned MAX_FRAME_LEN = 1522,
    parameter int unsigned STATUS_FILTER = 4
) (
    input  logic        gmii_rx_clk,
    input  logic        reset,
    input  logic [3:0]  rgmii_rxd_rise,
    input  logic [3:0]  rgmii_rxd_fall,
    input  logic        rgmii_rx_ctl_rise,
    input  logic        rgmii_rx_ctl_fall,
    output logic        gmii_rx_dv,
    output logic        gmii_rx_er,
    output logic [7:0]  gmii_rxd,
    output logic        pkt_valid,
    output logic [7:0]  pkt_data,
    output logic        pkt_sof,
    output logic        pkt_eof,
    output logic        pkt_err,
    output logic        link_up,
    output logic [1:0]  link_speed,
    output logic        full_duplex,
    output logic        false_carrier,
    output logic [15:0] frame_ok_cnt,
    output logic [15:0] frame_err_cnt
);

    localparam int unsigned LenW  = $clog2(MAX_FRAME_LEN + 1);
    localparam int unsigned FiltW = $clog2(STATUS_FILTER + 1);
    localparam logic [LenW-1:0]  LenMax  = LenW'(MAX_FRAME_LEN);
    localparam logic [FiltW-1:0] FiltMax = FiltW'(STATUS_FILTER);
    localparam logic [2:0]       PreMin  = 3'(MIN_PREAMBLE);

    localparam logic [1:0] StIdle     = 2'd0;
    localparam logic [1:0] StPreamble = 2'd1;
    localparam logic [1:0] StData     = 2'd2;
    localparam logic [1:0] StDrop     = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [2:0]       pre_cnt_q, pre_cnt_d, pre_eff;
    logic [7:0]       hold_q, hold_d;
    logic             hold_vld_q, hold_vld_d;
    logic             hold_sof_q, hold_sof_d;
    logic             err_q, err_d;
    logic [LenW-1:0]  len_q, len_d;
    logic             drop_cnt;
    logic             cand, status_upd;
    logic [3:0]       cand_q, cand_d;
    logic [FiltW-1:0] filt_cnt_q, filt_cnt_d;

    always_ff @(posedge gmii_rx_clk) begin
        if (reset) begin
            gmii_rx_dv <= 1'b0;
            gmii_rx_er <= 1'b0;
            gmii_rxd   <= 8'h00;
        end else begin
            gmii_rx_dv <= rgmii_rx_ctl_rise;
            gmii_rx_er <= rgmii_rx_ctl_rise ^ rgmii_rx_ctl_fall;
            gmii_rxd   <= {rgmii_rxd_fall, rgmii_rxd_rise};
        end
    end

    // In-band status: only idle cycles with matching nibbles and a legal speed qualify.
    always_comb begin
        cand = !gmii_rx_dv && !gmii_rx_er && (gmii_rxd[3:0] == gmii_rxd[7:4])
               && (gmii_rxd[2:1] != 2'b11);
        cand_d     = cand_q;
        filt_cnt_d = '0;
        if (cand) begin
            if ((filt_cnt_q != '0) && (gmii_rxd[3:0] == cand_q)) begin
                filt_cnt_d = (filt_cnt_q == FiltMax) ? FiltMax : filt_cnt_q + 1'b1;
            end else begin
                cand_d     = gmii_rxd[3:0];
                filt_cnt_d = FiltW'(1);
            end
        end
        status_upd = cand && (filt_cnt_d == FiltMax);
    end

    always_ff @(posedge gmii_rx_clk) begin
        if (reset) begin
            cand_q        <= 4'h0;
            filt_cnt_q    <= '0;
            link_up       <= 1'b0;
            link_speed    <= 2'b00;
            full_duplex   <= 1'b0;
            false_carrier <= 1'b0;
        end else begin
            cand_q        <= cand_d;
            filt_cnt_q    <= filt_cnt_d;
            false_carrier <= !gmii_rx_dv && gmii_rx_er && (gmii_rxd == 8'h0E);
            if (status_upd) begin
                link_up     <= gmii_rxd[0];
                link_speed  <= gmii_rxd[2:1];
                full_duplex <= gmii_rxd[3];
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        hold_d     = hold_q;
        hold_vld_d = hold_vld_q;
        hold_sof_d = hold_sof_q;
        err_d      = err_q;
        len_d      = len_q;
        drop_cnt   = 1'b0;
        pre_eff    = (state_q == StIdle) ? 3'd0 : pre_cnt_q;
        case (state_q)
            StIdle, StPreamble: begin
                if (!gmii_rx_dv) begin
                    state_d = StIdle;
                end else if (gmii_rx_er) begin
                    state_d  = StDrop;
                    drop_cnt = 1'b1;
                end else if (gmii_rxd == 8'h55) begin
                    state_d   = StPreamble;
                    pre_cnt_d = (pre_eff == 3'd7) ? 3'd7 : pre_eff + 3'd1;
                end else if ((gmii_rxd == 8'hD5) && (pre_eff >= PreMin)) begin
                    state_d    = StData;
                    err_d      = 1'b0;
                    len_d      = '0;
                    hold_vld_d = 1'b0;
                end else begin
                    state_d  = StDrop;
                    drop_cnt = 1'b1;
                end
            end
            StData: begin
                if (!gmii_rx_dv) begin
                    state_d    = StIdle;
                    hold_vld_d = 1'b0;
                    drop_cnt   = !hold_vld_q;
                end else if (hold_vld_q && (len_q == LenMax)) begin
                    // Held byte is the last allowed one; it leaves now with eof+err.
                    state_d    = StDrop;
                    hold_vld_d = 1'b0;
                end else begin
                    hold_d     = gmii_rxd;
                    hold_vld_d = 1'b1;
                    hold_sof_d = !hold_vld_q;
                    err_d      = err_q | gmii_rx_er;
                    len_d      = len_q + 1'b1;
                end
            end
            default: begin
                if (!gmii_rx_dv) state_d = StIdle;
            end
        endcase
    end

    assign pkt_valid = (state_q == StData) && hold_vld_q;
    assign pkt_eof   = pkt_valid && (!gmii_rx_dv || (len_q == LenMax));
    assign pkt_err   = pkt_eof && (err_q || gmii_rx_dv);
    assign pkt_sof   = pkt_valid && hold_sof_q;
    assign pkt_data  = hold_q;

    always_ff @(posedge gmii_rx_clk) begin
        if (reset) begin
            state_q       <= StIdle;
            pre_cnt_q     <= 3'd0;
            hold_q        <= 8'h00;
            hold_vld_q    <= 1'b0;
            hold_sof_q    <= 1'b0;
            err_q         <= 1'b0;
            len_q         <= '0;
            frame_ok_cnt  <= 16'h0000;
            frame_err_cnt <= 16'h0000;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            hold_q     <= hold_d;
            hold_vld_q <= hold_vld_d;
            hold_sof_q <= hold_sof_d;
            err_q      <= err_d;
            len_q      <= len_d;
            if (pkt_eof) begin
                if (pkt_err) frame_err_cnt <= frame_err_cnt + 16'd1;
                else         frame_ok_cnt  <= frame_ok_cnt + 16'd1;
            end else if (drop_cnt) begin
                frame_err_cnt <= frame_err_cnt + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_rgmii_rx_decode.sv
// Directed bench for rgmii_rx_decode: GMII/status/false-carrier vector table, then framing
// sequences on a default instance and a MIN_PREAMBLE=2 instance sharing the same inputs.
module tb_rgmii_rx_decode;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] rxd_rise, rxd_fall;
    logic       ctl_rise, ctl_fall;

    always #4 clk = ~clk;

    logic        gmii_rx_dv, gmii_rx_er, pkt_valid, pkt_sof, pkt_eof, pkt_err;
    logic [7:0]  gmii_rxd, pkt_data;
    logic        link_up, full_duplex, false_carrier;
    logic [1:0]  link_speed;
    logic [15:0] frame_ok_cnt, frame_err_cnt;

    logic        d2_rx_dv, d2_rx_er, d2_valid, d2_sof, d2_eof, d2_err;
    logic [7:0]  d2_rxd, d2_data;
    logic        d2_link, d2_dup, d2_fc;
    logic [1:0]  d2_speed;
    logic [15:0] d2_ok_cnt, d2_err_cnt;

    rgmii_rx_decode u_dut (
        .gmii_rx_clk(clk), .reset(reset),
        .rgmii_rxd_rise(rxd_rise), .rgmii_rxd_fall(rxd_fall),
        .rgmii_rx_ctl_rise(ctl_rise), .rgmii_rx_ctl_fall(ctl_fall),
        .gmii_rx_dv(gmii_rx_dv), .gmii_rx_er(gmii_rx_er), .gmii_rxd(gmii_rxd),
        .pkt_valid(pkt_valid), .pkt_data(pkt_data), .pkt_sof(pkt_sof),
        .pkt_eof(pkt_eof), .pkt_err(pkt_err),
        .link_up(link_up), .link_speed(link_speed), .full_duplex(full_duplex),
        .false_carrier(false_carrier),
        .frame_ok_cnt(frame_ok_cnt), .frame_err_cnt(frame_err_cnt)
    );

    rgmii_rx_decode #(.MIN_PREAMBLE(2)) u_dut2 (
        .gmii_rx_clk(clk), .reset(reset),
        .rgmii_rxd_rise(rxd_rise), .rgmii_rxd_fall(rxd_fall),
        .rgmii_rx_ctl_rise(ctl_rise), .rgmii_rx_ctl_fall(ctl_fall),
        .gmii_rx_dv(d2_rx_dv), .gmii_rx_er(d2_rx_er), .gmii_rxd(d2_rxd),
        .pkt_valid(d2_valid), .pkt_data(d2_data), .pkt_sof(d2_sof),
        .pkt_eof(d2_eof), .pkt_err(d2_err),
        .link_up(d2_link), .link_speed(d2_speed), .full_duplex(d2_dup),
        .false_carrier(d2_fc),
        .frame_ok_cnt(d2_ok_cnt), .frame_err_cnt(d2_err_cnt)
    );

    typedef struct packed {
        logic [7:0] data;
        logic       sof;
        logic       eof;
        logic       err;
    } beat_t;

    typedef struct {
        logic       cr, cf;
        logic [3:0] rn, fn;
        logic       e_dv, e_er;
        logic [7:0] e_rxd;
        logic       e_link;
        logic [1:0] e_speed;
        logic       e_dup, e_fc;
    } vec_t;

    beat_t beats[$];
    int    d2_beats = 0;
    vec_t  vecs[$];
    int    checks = 0;
    int    errors = 0;

    always @(negedge clk) begin
        if (pkt_valid) beats.push_back({pkt_data, pkt_sof, pkt_eof, pkt_err});
        if (d2_valid) d2_beats++;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_raw(input logic cr, input logic cf, input logic [3:0] rn,
                            input logic [3:0] fn);
        ctl_rise = cr;
        ctl_fall = cf;
        rxd_rise = rn;
        rxd_fall = fn;
        tick();
    endtask

    task automatic send_byte(input logic dv, input logic er, input logic [7:0] b);
        send_raw(dv, dv ^ er, b[3:0], b[7:4]);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) send_byte(1'b0, 1'b0, 8'hDD);
    endtask

    task automatic payload(input int len, input int er_idx);
        for (int i = 1; i <= len; i++) begin
            send_byte(1'b1, i == er_idx, 8'(i));
            if (i == er_idx) check("gmii_rx_er on errored byte", gmii_rx_er, 1);
        end
    endtask

    task automatic frame(input int npre, input int len, input int er_idx);
        for (int i = 0; i < npre; i++) send_byte(1'b1, 1'b0, 8'h55);
        send_byte(1'b1, 1'b0, 8'hD5);
        payload(len, er_idx);
        idle(3);
    endtask

    // Payload bytes are always 1,2,3,... so the expected data is the beat index + 1.
    task automatic check_frame(input string name, input int start, input int exp_n,
                               input logic exp_err);
        int n;
        int bad;
        n   = beats.size() - start;
        bad = 0;
        check({name, " beat count"}, n, exp_n);
        for (int i = 0; i < n; i++) begin
            if (beats[start+i].data != 8'(i + 1)) bad++;
            if (beats[start+i].sof != (i == 0)) bad++;
            if (beats[start+i].eof != (i == n - 1)) bad++;
            if (beats[start+i].err != ((i == n - 1) && exp_err)) bad++;
        end
        check({name, " beat fields"}, bad, 0);
    endtask

    task automatic check_counts(input string name, input int ok1, input int err1,
                                input int ok2, input int err2);
        check({name, " ok_cnt"}, frame_ok_cnt, ok1);
        check({name, " err_cnt"}, frame_err_cnt, err1);
        check({name, " dut2 ok_cnt"}, d2_ok_cnt, ok2);
        check({name, " dut2 err_cnt"}, d2_err_cnt, err2);
    endtask

    task automatic add(input logic cr, input logic cf, input logic [3:0] rn,
                       input logic [3:0] fn, input logic e_dv, input logic e_er,
                       input logic [7:0] e_rxd, input logic e_link, input logic [1:0] e_speed,
                       input logic e_dup, input logic e_fc);
        vecs.push_back('{cr, cf, rn, fn, e_dv, e_er, e_rxd, e_link, e_speed, e_dup, e_fc});
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int s, s2, eofs;
        reset    = 1'b1;
        ctl_rise = 1'b0;
        ctl_fall = 1'b0;
        rxd_rise = 4'hD;
        rxd_fall = 4'hD;

        //  cr cf rn    fn    dv er rxd    link speed dup fc
        add(0, 0, 4'hD, 4'hD, 0, 0, 8'hDD, 0, 2'd0, 0, 0);
        add(0, 0, 4'hD, 4'hD, 0, 0, 8'hDD, 0, 2'd0, 0, 0);
        add(0, 0, 4'hD, 4'hD, 0, 0, 8'hDD, 0, 2'd0, 0, 0);
        add(0, 0, 4'hD, 4'hD, 0, 0, 8'hDD, 0, 2'd0, 0, 0);
        add(0, 0, 4'h5, 4'h5, 0, 0, 8'h55, 1, 2'd2, 1, 0);
        add(0, 0, 4'hD, 4'hD, 0, 0, 8'hDD, 1, 2'd2, 1, 0);
        add(0, 0, 4'h5, 4'h5, 0, 0, 8'h55, 1, 2'd2, 1, 0);
        add(0, 0, 4'hD, 4'hD, 0, 0, 8'hDD, 1, 2'd2, 1, 0);
        add(0, 1, 4'hE, 4'h0, 0, 1, 8'h0E, 1, 2'd2, 1, 0);
        add(0, 0, 4'hD, 4'hD, 0, 0, 8'hDD, 1, 2'd2, 1, 1);
        add(0, 1, 4'hF, 4'h0, 0, 1, 8'h0F, 1, 2'd2, 1, 0);
        add(0, 0, 4'h3, 4'h3, 0, 0, 8'h33, 1, 2'd2, 1, 0);
        add(0, 0, 4'h3, 4'h3, 0, 0, 8'h33, 1, 2'd2, 1, 0);
        add(0, 0, 4'h3, 4'h3, 0, 0, 8'h33, 1, 2'd2, 1, 0);
        add(0, 0, 4'h3, 4'h3, 0, 0, 8'h33, 1, 2'd2, 1, 0);
        add(0, 0, 4'h7, 4'h7, 0, 0, 8'h77, 1, 2'd1, 0, 0);
        add(0, 0, 4'h7, 4'h7, 0, 0, 8'h77, 1, 2'd1, 0, 0);
        add(0, 0, 4'h7, 4'h7, 0, 0, 8'h77, 1, 2'd1, 0, 0);
        add(0, 0, 4'h7, 4'h7, 0, 0, 8'h77, 1, 2'd1, 0, 0);
        add(0, 0, 4'h7, 4'h7, 0, 0, 8'h77, 1, 2'd1, 0, 0);
        add(0, 0, 4'h2, 4'h1, 0, 0, 8'h12, 1, 2'd1, 0, 0);
        add(1, 1, 4'h5, 4'h5, 1, 0, 8'h55, 1, 2'd1, 0, 0);
        add(1, 0, 4'hA, 4'hA, 1, 1, 8'hAA, 1, 2'd1, 0, 0);
        add(0, 0, 4'hD, 4'hD, 0, 0, 8'hDD, 1, 2'd1, 0, 0);
        add(0, 1, 4'h0, 4'h0, 0, 1, 8'h00, 1, 2'd1, 0, 0);
        add(0, 0, 4'hD, 4'hD, 0, 0, 8'hDD, 1, 2'd1, 0, 0);

        tick();
        tick();
        reset = 1'b0;
        check("reset gmii_rx_dv", gmii_rx_dv, 0);
        check("reset gmii_rxd", gmii_rxd, 0);
        check("reset pkt_valid", pkt_valid, 0);
        check("reset link_up", link_up, 0);
        check("reset link_speed", link_speed, 0);
        check("reset false_carrier", false_carrier, 0);
        check_counts("reset", 0, 0, 0, 0);

        foreach (vecs[i]) begin
            send_raw(vecs[i].cr, vecs[i].cf, vecs[i].rn, vecs[i].fn);
            check($sformatf("vec%0d gmii_rx_dv", i), gmii_rx_dv, vecs[i].e_dv);
            check($sformatf("vec%0d gmii_rx_er", i), gmii_rx_er, vecs[i].e_er);
            check($sformatf("vec%0d gmii_rxd", i), gmii_rxd, vecs[i].e_rxd);
            check($sformatf("vec%0d link_up", i), link_up, vecs[i].e_link);
            check($sformatf("vec%0d link_speed", i), link_speed, vecs[i].e_speed);
            check($sformatf("vec%0d full_duplex", i), full_duplex, vecs[i].e_dup);
            check($sformatf("vec%0d false_carrier", i), false_carrier, vecs[i].e_fc);
        end
        check("preamble er drop err_cnt", frame_err_cnt, 1);

        do_reset();
        idle(2);

        s = beats.size(); s2 = d2_beats;
        frame(7, 64, 0);
        check_frame("good64", s, 64, 1'b0);
        check("good64 dut2 beats", d2_beats - s2, 64);
        check_counts("good64", 1, 0, 1, 0);

        s = beats.size(); s2 = d2_beats;
        frame(7, 64, 10);
        check_frame("er64", s, 64, 1'b1);
        check_counts("er64", 1, 1, 1, 1);

        s = beats.size(); s2 = d2_beats;
        send_byte(1'b1, 1'b0, 8'h55);
        send_byte(1'b1, 1'b0, 8'h55);
        send_byte(1'b1, 1'b0, 8'hAA);
        payload(3, 0);
        idle(3);
        check_frame("badpre", s, 0, 1'b0);
        check("badpre dut2 beats", d2_beats - s2, 0);
        check_counts("badpre", 1, 2, 1, 2);

        s = beats.size(); s2 = d2_beats;
        frame(0, 3, 0);
        check_frame("lone sfd", s, 0, 1'b0);
        check_counts("lone sfd", 1, 3, 1, 3);

        s = beats.size(); s2 = d2_beats;
        frame(1, 3, 0);
        check_frame("pre1", s, 3, 1'b0);
        check("pre1 dut2 beats", d2_beats - s2, 0);
        check_counts("pre1", 2, 3, 1, 4);

        s = beats.size(); s2 = d2_beats;
        frame(2, 1, 0);
        check_frame("single byte", s, 1, 1'b0);
        check("single byte dut2 beats", d2_beats - s2, 1);
        check_counts("single byte", 3, 3, 2, 4);

        s = beats.size(); s2 = d2_beats;
        frame(1, 0, 0);
        check_frame("empty", s, 0, 1'b0);
        check_counts("empty", 3, 4, 2, 5);

        s = beats.size(); s2 = d2_beats;
        frame(7, 1600, 0);
        check_frame("trunc", s, 1522, 1'b1);
        check("trunc dut2 beats", d2_beats - s2, 1522);
        check_counts("trunc", 3, 5, 2, 6);

        s = beats.size(); s2 = d2_beats;
        frame(7, 64, 0);
        check_frame("after trunc", s, 64, 1'b0);
        check_counts("after trunc", 4, 5, 3, 6);

        s = beats.size();
        send_byte(1'b1, 1'b0, 8'h55);
        send_byte(1'b1, 1'b0, 8'hD5);
        payload(10, 0);
        check("mid-frame pkt_valid before reset", pkt_valid, 1);
        reset = 1'b1;
        send_byte(1'b1, 1'b0, 8'h0B);
        check("reset mid-frame pkt_valid", pkt_valid, 0);
        check("reset mid-frame pkt_eof", pkt_eof, 0);
        check("reset mid-frame gmii_rx_dv", gmii_rx_dv, 0);
        check("reset mid-frame gmii_rxd", gmii_rxd, 0);
        check("reset mid-frame link_up", link_up, 0);
        check_counts("reset mid-frame", 0, 0, 0, 0);
        send_byte(1'b1, 1'b0, 8'h0C);
        reset = 1'b0;
        idle(3);
        eofs = 0;
        for (int i = s; i < beats.size(); i++) if (beats[i].eof) eofs++;
        check("reset mid-frame eof beats", eofs, 0);
        check_counts("after reset", 0, 0, 0, 0);

        send_byte(1'b0, 1'b1, 8'h0E);
        check("fc before pulse", false_carrier, 0);
        idle(1);
        check("fc pulse", false_carrier, 1);
        idle(1);
        check("fc pulse end", false_carrier, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
